// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop sync, debounce and press pulse for buttons A/B/C.
// Define BTN_COND_LOCKOUT_EN to suppress presses while another button is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    output logic       p0,
    output logic       p1,
    output logic       p2,
    output logic [2:0] held,
    output logic       any_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       deb;
    logic [2:0]       deb_nxt;
    logic [2:0]       rise;
    logic [2:0]       fire;
    logic [2:0]       pulse;
    logic             any_r;
    logic [CNT_W-1:0] cnt     [3];
    logic [CNT_W-1:0] cnt_nxt [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_nxt[i] = deb[i];
            cnt_nxt[i] = '0;
            if (s2[i] != deb[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    deb_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = deb_nxt & ~deb;

`ifdef BTN_COND_LOCKOUT_EN
    // A press only counts if neither other button is (or becomes) held.
    always_comb begin
        fire    = '0;
        fire[0] = rise[0] & ~deb_nxt[1] & ~deb_nxt[2];
        fire[1] = rise[1] & ~deb_nxt[0] & ~deb_nxt[2];
        fire[2] = rise[2] & ~deb_nxt[0] & ~deb_nxt[1];
    end
`else
    assign fire = rise;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            pulse <= '0;
            any_r <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            deb   <= deb_nxt;
            pulse <= fire;
            any_r <= |fire;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign p0        = pulse[0];
    assign p1        = pulse[1];
    assign p2        = pulse[2];
    assign held      = deb;
    assign any_pulse = any_r;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table-driven vectors with a scoreboard queue.
// Expected values follow the press/release latency of k+1+DEBOUNCE_CYCLES.
module tb_button_conditioner;

    typedef struct {
        string      name;
        int         step;
        logic       rst;
        logic [2:0] btn;
        logic [2:0] p;
        logic [2:0] held;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] btn_raw;
    logic       p0;
    logic       p1;
    logic       p2;
    logic [2:0] held;
    logic       any_pulse;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef BTN_COND_LOCKOUT_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .p0(p0),
        .p1(p1),
        .p2(p2),
        .held(held),
        .any_pulse(any_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic inw(int s, int a, int b);
        return (s >= a) && (s < b);
    endfunction

    task automatic add(input string nm, input int s, input logic r,
                       input logic [2:0] b, input logic [2:0] p,
                       input logic [2:0] h);
        vec_t v;
        v.name = nm;
        v.step = s;
        v.rst  = r;
        v.btn  = b;
        v.p    = p;
        v.held = h;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst     = v.rst;
        btn_raw = v.btn;
        sb.push_back(v);
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops the expectation for the edge just taken.
    always begin
        vec_t       e;
        logic [2:0] pa;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            pa = {p2, p1, p0};
            n_checks++;
            if (pa !== e.p || held !== e.held || any_pulse !== (|e.p)) begin
                n_fail++;
                $display("FAIL %s step %0d: got p=%b held=%b any=%b, want p=%b held=%b any=%b",
                         e.name, e.step, pa, held, any_pulse,
                         e.p, e.held, |e.p);
            end
        end
    end

    initial begin
        logic [2:0] b;
        logic [2:0] p;
        logic [2:0] h;

        rst     = 1'b1;
        btn_raw = 3'b000;

        for (int s = 0; s < 3; s++) begin
            add("reset", s, 1'b1, 3'b000, 3'b000, 3'b000);
        end

        for (int s = 0; s < 28; s++) begin
            b = (s < 20) ? 3'b010 : 3'b000;
            h = inw(s, 5, 25) ? 3'b010 : 3'b000;
            p = (s == 5) ? 3'b010 : 3'b000;
            add("clean", s, 1'b0, b, p, h);
        end

        for (int s = 0; s < 29; s++) begin
            b    = '0;
            b[0] = (s < 10) ? ((s % 2) == 0) : (s < 21);
            h    = inw(s, 15, 26) ? 3'b001 : 3'b000;
            p    = (s == 15) ? 3'b001 : 3'b000;
            add("bounce", s, 1'b0, b, p, h);
        end

        for (int s = 0; s < 12; s++) begin
            b = (s < 3) ? 3'b100 : 3'b000;
            add("glitch", s, 1'b0, b, 3'b000, 3'b000);
        end

        for (int s = 0; s < 20; s++) begin
            b = (s < 12) ? 3'b101 : 3'b000;
            h = inw(s, 5, 17) ? 3'b101 : 3'b000;
            p = (s == 5 && !LOCK) ? 3'b101 : 3'b000;
            add("simul", s, 1'b0, b, p, h);
        end

        for (int s = 0; s < 35; s++) begin
            b    = '0;
            b[0] = (s < 26);
            b[2] = (s >= 10) && (s < 26);
            h    = '0;
            h[0] = inw(s, 5, 31);
            h[2] = inw(s, 15, 31);
            p    = '0;
            p[0] = (s == 5);
            p[2] = (s == 15) && !LOCK;
            add("overlap", s, 1'b0, b, p, h);
        end

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // Reset during debounce: first edge with rst low is step 4.
        for (int s = 0; s < 23; s++) begin
            vec_t v;
            v.name = "rst_mid";
            v.step = s;
            v.rst  = (s == 2) || (s == 3);
            v.btn  = (s < 15) ? 3'b010 : 3'b000;
            v.held = inw(s, 9, 20) ? 3'b010 : 3'b000;
            v.p    = (s == 9) ? 3'b010 : 3'b000;
            apply(v);
        end

        repeat (3) begin
            if (sb.size() > 0) @(posedge clk);
        end
        #3;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
